// File: rtl/adc_spi_reader_if.sv
// Pin bundle of the SPI ADC reader: run control, ADC serial pins and the
// parallel sample handed to the averager.
interface adc_spi_reader_if #(
  parameter int N = 8
);
  logic         run;
  logic         adc_miso;
  logic         adc_csb;
  logic         adc_sclk;
  logic [N-1:0] sample;
  logic         sample_valid;
  logic         busy;

  modport master (
    input  run,
    input  adc_miso,
    output adc_csb,
    output adc_sclk,
    output sample,
    output sample_valid,
    output busy
  );

  modport slave (
    output run,
    output adc_miso,
    input  adc_csb,
    input  adc_sclk,
    input  sample,
    input  sample_valid,
    input  busy
  );
endinterface

// File: rtl/adc_spi_reader.sv
// Clocks N-bit MSB-first words out of an SPI-style ADC and presents each
// completed word as a parallel sample with a one-cycle valid strobe.
module adc_spi_reader #(
  parameter int N   = 8,
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic             cclk,
  input  logic             rstb,
  adc_spi_reader_if.master bus
);
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(N);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] div_cnt_r, div_cnt_s;
  logic [BW-1:0] bit_cnt_r, bit_cnt_s;
  logic [GW-1:0] gap_cnt_r, gap_cnt_s;
  logic [N-1:0]  shift_r, shift_s;
  logic [N-1:0]  sample_r, sample_s;
  logic          valid_r, valid_s;
  logic          csb_r;
  logic          sclk_r;
  logic          busy_r;
  logic          tick_s;

  assign tick_s = (div_cnt_r == DIV_LAST);

  // State register.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus the counter and shift-register updates it implies.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    shift_s   = shift_r;
    sample_s  = sample_r;
    valid_s   = 1'b0;

    if (state_r == ST_IDLE) begin
      div_cnt_s = '0;
    end else if (tick_s) begin
      div_cnt_s = '0;
    end else begin
      div_cnt_s = div_cnt_r + DIV_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.run) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_s   = ST_HI;
          bit_cnt_s = '0;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_HI: begin
        // MISO is taken on the last cycle of the high phase, just before SCLK falls.
        if (tick_s) begin
          shift_s = {shift_r[N-2:0], bus.adc_miso};
          if (bit_cnt_r == BIT_LAST) begin
            sample_s  = {shift_r[N-2:0], bus.adc_miso};
            valid_s   = 1'b1;
            gap_cnt_s = '0;
            state_s   = ST_GAP;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
            state_s   = ST_LO;
          end
        end else begin
          state_s = ST_HI;
        end
      end
      ST_LO: begin
        if (tick_s) begin
          state_s = ST_HI;
        end else begin
          state_s = ST_LO;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_s = '0;
            if (bus.run) begin
              state_s = ST_SETUP;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            gap_cnt_s = gap_cnt_r + GAP_ONE;
            state_s   = ST_GAP;
          end
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and pin registers; pins decode the next state so they change together with it.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      shift_r   <= '0;
      sample_r  <= '0;
      valid_r   <= 1'b0;
      csb_r     <= 1'b1;
      sclk_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      shift_r   <= shift_s;
      sample_r  <= sample_s;
      valid_r   <= valid_s;
      csb_r     <= (state_s == ST_IDLE) || (state_s == ST_GAP);
      sclk_r    <= (state_s == ST_HI);
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign bus.adc_csb      = csb_r;
  assign bus.adc_sclk     = sclk_r;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = valid_r;
  assign bus.busy         = busy_r;
endmodule
